sm_sat_accum: RTL and testbench

//  Streaming saturating accumulator for sign-magnitude samples (bit MSB = sign, rest = magnitude).

---
 rtl/sm_sat_accum_pkg.sv | 23 ++
 rtl/sm_sat_accum_conv.sv | 23 ++
 rtl/sm_sat_accum.sv | 99 +++++++++
 tb/tb_sm_sat_accum.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sm_sat_accum_pkg.sv
// sm_sat_accum_pkg: shared sign-magnitude widths, FSM encoding and conversion helpers.
package sm_sat_accum_pkg;
  localparam int DATA_W_DEF = 36;
  localparam int GUARD_W_DEF = 8;
  localparam int ACC_W_DEF = DATA_W_DEF + GUARD_W_DEF;
  localparam logic [1:0] ST_ACC = 2'd0;
  localparam logic [1:0] ST_FIN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  typedef logic [DATA_W_DEF-1:0] sm_t;
  typedef logic [ACC_W_DEF-1:0] acc_t;
  function automatic acc_t sm2tc(input sm_t s);
    acc_t m;
    m = acc_t'(s[DATA_W_DEF-2:0]);
    return s[DATA_W_DEF-1] ? -m : m;
  endfunction
  function automatic sm_t tc2sm_sat(input acc_t a, input logic sat_en);
    acc_t m;
    logic ovf;
    m = a[ACC_W_DEF-1] ? -a : a;
    ovf = |m[ACC_W_DEF-1:DATA_W_DEF-1];
    return {a[ACC_W_DEF-1], (ovf && sat_en) ? {(DATA_W_DEF-1){1'b1}} : m[DATA_W_DEF-2:0]};
  endfunction
endpackage

// File: rtl/sm_sat_accum_conv.sv
// sm_tc_conv: sign-magnitude to two's complement and back, with optional magnitude clamp.
module sm_tc_conv
  import sm_sat_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [DATA_W-1:0] i_sm,
  output logic [ACC_W-1:0]  o_tc,
  input  logic [ACC_W-1:0]  i_tc,
  output logic [DATA_W-1:0] o_sm,
  output logic              o_ovf
);
  logic [ACC_W-1:0] w_mag;
  logic [ACC_W-1:0] w_abs;
  // Negating a zero magnitude yields zero, so -0 folds to +0 for free.
  assign w_mag = {{(ACC_W-DATA_W+1){1'b0}}, i_sm[DATA_W-2:0]};
  assign o_tc = i_sm[DATA_W-1] ? -w_mag : w_mag;
  assign w_abs = i_tc[ACC_W-1] ? -i_tc : i_tc;
  assign o_ovf = |w_abs[ACC_W-1:DATA_W-1];
  assign o_sm = {i_tc[ACC_W-1], (o_ovf && SAT_EN) ? {(DATA_W-1){1'b1}} : w_abs[DATA_W-2:0]};
endmodule

// File: rtl/sm_sat_accum.sv
// sm_sat_accum: frames of sign-magnitude samples summed in a wide accumulator,
// emitted as a saturated sign-magnitude result with overflow flag and beat count.
module sm_sat_accum
  import sm_sat_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF,
  parameter int MAX_LEN = 256,
  parameter int CNT_W = 9,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_cnt
);
  localparam int ACC_W = DATA_W + GUARD_W;
  logic [1:0]        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat_st;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sat;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [ACC_W-1:0]  w_x;
  logic [DATA_W-1:0] w_sm;
  logic              w_ovf;
  logic [ACC_W:0]    w_sum;
  logic              w_add_ovf;
  logic [ACC_W-1:0]  w_max;
  logic [ACC_W-1:0]  w_acc_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              w_beat;
  logic              w_end;
  sm_tc_conv #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT_EN(SAT_EN)) u_conv (
    .i_sm  (in_data),
    .o_tc  (w_x),
    .i_tc  (r_acc),
    .o_sm  (w_sm),
    .o_ovf (w_ovf)
  );
  // One extra sign bit exposes accumulator overflow as a mismatch of the top two bits.
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_x[ACC_W-1], w_x};
  assign w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_max = {1'b0, {(ACC_W-1){1'b1}}};
  assign w_acc_nx = (w_add_ovf && SAT_EN) ? (w_sum[ACC_W] ? -w_max : w_max) : w_sum[ACC_W-1:0];
  assign w_cnt_nx = r_cnt + 1'b1;
  assign w_beat = in_valid && (r_state == ST_ACC);
  assign w_end = in_last || (w_cnt_nx == CNT_W'(MAX_LEN));
  assign in_ready = (r_state == ST_ACC);
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  assign out_sat = r_out_sat;
  assign out_cnt = r_out_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_acc <= '0;
      r_cnt <= '0;
      r_sat_st <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_sat <= 1'b0;
      r_out_cnt <= '0;
    end else begin
      case (r_state)
        ST_ACC: if (w_beat) begin
          r_acc <= w_acc_nx;
          r_cnt <= w_cnt_nx;
          r_sat_st <= r_sat_st | w_add_ovf;
          if (w_end) r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_out_data <= w_sm;
          r_out_sat <= r_sat_st | w_ovf;
          r_out_cnt <= r_cnt;
          r_out_valid <= 1'b1;
          r_acc <= '0;
          r_cnt <= '0;
          r_sat_st <= 1'b0;
          r_state <= ST_HOLD;
        end
        ST_HOLD: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state <= ST_ACC;
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_sat_accum.sv
// tb_sm_sat_accum: directed frame vectors plus stall and reset sequences for sm_sat_accum.
module tb_sm_sat_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [35:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [35:0] out_data;
  logic out_sat;
  logic [2:0] out_cnt;
  int n_pass = 0;
  int n_tot = 0;
  typedef struct {
    int n;
    logic [3:0][35:0] d;
    bit last;
    logic [35:0] e_data;
    bit e_sat;
    logic [2:0] e_cnt;
  } vec_t;
  vec_t vecs[10];
  sm_sat_accum #(.DATA_W(36), .GUARD_W(8), .MAX_LEN(4), .CNT_W(3), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_cnt   (out_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [35:0] neg(input logic [35:0] m);
    return 36'h8_0000_0000 | m;
  endfunction
  function automatic vec_t mk(input int n, input logic [35:0] d0, d1, d2, d3,
                              input bit last, input logic [35:0] e, input bit s, input logic [2:0] c);
    vec_t v;
    v.n = n;
    v.d[0] = d0;
    v.d[1] = d1;
    v.d[2] = d2;
    v.d[3] = d3;
    v.last = last;
    v.e_data = e;
    v.e_sat = s;
    v.e_cnt = c;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic run_frame(input vec_t v, input string nm);
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_data = v.d[i];
      in_last = v.last && (i == v.n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk({nm, " fin_nvalid"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({nm, " result"}, {out_valid, out_sat, out_cnt, out_data},
        {1'b1, v.e_sat, v.e_cnt, v.e_data});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({nm, " idle"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask
  initial begin
    vecs[0] = mk(3, 36'd5, neg(36'd3), 36'd10, 36'd0, 1, 36'hC, 0, 3'd3);
    vecs[1] = mk(2, neg(36'd7), 36'd7, 36'd0, 36'd0, 1, 36'd0, 0, 3'd2);
    vecs[2] = mk(1, 36'h8_0000_0000, 36'd0, 36'd0, 36'd0, 1, 36'd0, 0, 3'd1);
    vecs[3] = mk(2, 36'h7_FFFF_FFFF, 36'h7_FFFF_FFFF, 36'd0, 36'd0, 1, 36'h7_FFFF_FFFF, 1, 3'd2);
    vecs[4] = mk(2, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'd0, 36'd0, 1, 36'hF_FFFF_FFFF, 1, 3'd2);
    vecs[5] = mk(1, 36'd1, 36'd0, 36'd0, 36'd0, 1, 36'd1, 0, 3'd1);
    vecs[6] = mk(4, 36'd1, 36'd1, 36'd1, 36'd1, 0, 36'd4, 0, 3'd4);
    vecs[7] = mk(2, 36'd1, 36'd1, 36'd0, 36'd0, 1, 36'd2, 0, 3'd2);
    vecs[8] = mk(4, 36'd1, 36'd1, 36'd1, 36'd1, 1, 36'd4, 0, 3'd4);
    vecs[9] = mk(3, neg(36'd5), neg(36'd3), 36'd2, 36'd0, 1, neg(36'd6), 0, 3'd3);
    #12;
    chk("reset", {22'd0, in_ready, out_valid, out_sat, out_cnt, out_data}, {22'd0, 1'b1, 1'b0, 1'b0, 3'd0, 36'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) run_frame(vecs[k], $sformatf("vec%0d", k));
    // HOLD stall with a beat pending: nothing accepted until the result is taken.
    in_valid = 1'b1;
    in_data = 36'd3;
    in_last = 1'b1;
    @(posedge clk); #1;
    in_data = 36'd100;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d", c), {in_ready, out_valid, out_sat, out_cnt, out_data},
          {1'b0, 1'b1, 1'b0, 3'd1, 36'd3});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {62'd0, out_valid, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk); #1;
    chk("stall_next", {out_valid, out_sat, out_cnt, out_data}, {1'b1, 1'b0, 3'd1, 36'd100});
    @(posedge clk); #1;
    out_ready = 1'b0;
    // Reset mid-frame discards the partial sum.
    in_valid = 1'b1;
    in_data = 36'd50;
    @(posedge clk); #1;
    in_data = 36'd60;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_mid", {22'd0, in_ready, out_valid, out_sat, out_cnt, out_data}, {22'd0, 1'b1, 1'b0, 1'b0, 3'd0, 36'd0});
    rst = 1'b0;
    run_frame(mk(1, 36'd7, 36'd0, 36'd0, 36'd0, 1, 36'd7, 0, 3'd1), "after_rst_mid");
    // Reset while a result is held drops it.
    in_valid = 1'b1;
    in_data = 36'd9;
    in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk); #1;
    chk("hold_pre", {out_valid, out_cnt, out_data}, {1'b1, 3'd1, 36'd9});
    rst = 1'b1;
    #2;
    chk("rst_hold", {22'd0, in_ready, out_valid, out_sat, out_cnt, out_data}, {22'd0, 1'b1, 1'b0, 1'b0, 3'd0, 36'd0});
    rst = 1'b0;
    run_frame(mk(1, 36'd2, 36'd0, 36'd0, 36'd0, 1, 36'd2, 0, 3'd1), "after_rst_hold");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
